// File: rtl/serial_port_arbiter_if.sv
// Signal bundle between the serial port arbiter, its two producers, the Serial_port FIFO
// and the drained-byte consumer. The arbiter uses master; its neighbours use slave.
interface serial_port_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0;
    logic [DATA_W-1:0] data0;
    logic              ack0;
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              ack1;
    logic              sp_w_e;
    logic [DATA_W-1:0] sp_data_in;
    logic              sp_f_f;
    logic              sp_r_e;
    logic [DATA_W-1:0] sp_data_out;
    logic              sp_e_f;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        input  req0, data0, req1, data1, sp_f_f, sp_data_out, sp_e_f, out_ready,
        output ack0, ack1, sp_w_e, sp_data_in, sp_r_e, out_valid, out_data
    );

    modport slave (
        output req0, data0, req1, data1, sp_f_f, sp_data_out, sp_e_f, out_ready,
        input  ack0, ack1, sp_w_e, sp_data_in, sp_r_e, out_valid, out_data
    );
endinterface

// File: rtl/serial_port_arbiter.sv
// Round-robin write arbiter (1 byte / 2 cycles, stalls on full) plus 3-cycle FIFO drain to a
// valid/ready stream held until accepted. Define SP_ARB_BURST_EN for BURST_LEN-write grants.
module serial_port_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_port_arbiter_if.master bus
);

    typedef enum logic       {W_IDLE, W_WRITE}        w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_CAP} r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic              last_grant_q, last_grant_d;
    logic              sp_w_e_q, sp_w_e_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] sp_data_in_q, sp_data_in_d;
    logic              sp_r_e_q, sp_r_e_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              wr_go;
    logic              winner;
    logic              keep_grant;

`ifdef SP_ARB_BURST_EN
    localparam int              CNT_W   = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);

    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             last_req;

    // A zero count means no burst is in progress, so reset state still lets requester 0 win.
    assign last_req   = last_grant_q ? bus.req1 : bus.req0;
    assign keep_grant = (burst_cnt_q != '0) && (burst_cnt_q < CNT_MAX);

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (wr_go) begin
            burst_cnt_d = ((winner == last_grant_q) && keep_grant) ? burst_cnt_q + 1'b1
                                                                   : CNT_W'(1);
        end else if ((w_state_q == W_IDLE) && !last_req) begin
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) burst_cnt_q <= '0;
        else        burst_cnt_q <= burst_cnt_d;
    end
`else
    localparam int unused_burst_len = BURST_LEN;
    assign keep_grant = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            last_grant_q <= 1'b1;
            sp_w_e_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            sp_data_in_q <= '0;
            sp_r_e_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            last_grant_q <= last_grant_d;
            sp_w_e_q     <= sp_w_e_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            sp_data_in_q <= sp_data_in_d;
            sp_r_e_q     <= sp_r_e_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // W_WRITE always returns to idle, so the full flag is re-sampled before every write.
    always_comb begin
        w_state_d = w_state_q;
        wr_go     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (!bus.sp_f_f && (bus.req0 || bus.req1)) begin
                    wr_go     = 1'b1;
                    w_state_d = W_WRITE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (bus.req0 && bus.req1) winner = keep_grant ? last_grant_q : ~last_grant_q;
        else                      winner = bus.req1;
    end

    always_comb begin
        sp_w_e_d     = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        sp_data_in_d = sp_data_in_q;
        last_grant_d = last_grant_q;
        if (wr_go) begin
            sp_w_e_d     = 1'b1;
            sp_data_in_d = winner ? bus.data1 : bus.data0;
            ack0_d       = ~winner;
            ack1_d       = winner;
            last_grant_d = winner;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (!bus.sp_e_f && !out_valid_q) r_state_d = R_FETCH;
            R_FETCH: r_state_d = R_CAP;
            default: r_state_d = R_IDLE;
        endcase
    end

    // FIFO data lands one cycle after the r_e pulse, which is exactly the R_CAP cycle.
    always_comb begin
        sp_r_e_d    = (r_state_d == R_FETCH);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (r_state_q == R_CAP) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.sp_data_out;
        end
    end

    assign bus.sp_w_e     = sp_w_e_q;
    assign bus.sp_data_in = sp_data_in_q;
    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.sp_r_e     = sp_r_e_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;

endmodule

// File: tb/tb_serial_port_arbiter.sv
// Bench for serial_port_arbiter: behavioural Serial_port FIFO, queue-driven requesters and
// write/read scoreboards; expected bytes are queued when stimulus is applied.
module tb_serial_port_arbiter;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] dat;
        logic       who;
    } wexp_t;

    logic       clk;
    logic       rst_n;
    logic       ff_force;
    logic       pl_vld;
    logic [7:0] pl_dat;
    int         fcnt, wp, rp;
    logic [7:0] fmem [DEPTH];
    logic       do_wr, do_rd;
    logic       prev_we;
    int         wr_cnt, re_cnt;
    int         n_vec, n_err;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    wexp_t      wr_exp[$];
    logic [7:0] rd_exp[$];

    serial_port_arbiter_if #(.DATA_W(8)) sp_if ();

    serial_port_arbiter #(.DATA_W(8), .BURST_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial_port model: one write and one read per cycle, read data valid the cycle after r_e.
    assign sp_if.sp_f_f = (fcnt == DEPTH) || ff_force;
    assign sp_if.sp_e_f = (fcnt == 0);
    assign do_wr = (sp_if.sp_w_e || pl_vld) && (fcnt < DEPTH);
    assign do_rd = sp_if.sp_r_e && (fcnt > 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= 0;
            wp   <= 0;
            rp   <= 0;
            sp_if.sp_data_out <= 8'h00;
        end else begin
            if (do_wr) begin
                fmem[wp] <= pl_vld ? pl_dat : sp_if.sp_data_in;
                wp       <= (wp + 1) % DEPTH;
            end
            if (do_rd) begin
                sp_if.sp_data_out <= fmem[rp];
                rp                <= (rp + 1) % DEPTH;
            end
            fcnt <= fcnt + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Requesters hold req/data until their ack, then present the next queued byte.
    always @(negedge clk) begin
        if (sp_if.ack0 && q0.size() != 0) void'(q0.pop_front());
        if (sp_if.ack1 && q1.size() != 0) void'(q1.pop_front());
        sp_if.req0  = (q0.size() != 0);
        sp_if.data0 = (q0.size() != 0) ? q0[0] : 8'h00;
        sp_if.req1  = (q1.size() != 0);
        sp_if.data1 = (q1.size() != 0) ? q1[0] : 8'h00;
    end

    always @(negedge clk) begin
        wexp_t e;
        if (rst_n) begin
            if (sp_if.sp_w_e) begin
                wr_cnt++;
                chk("wr_while_full", 32'(sp_if.sp_f_f), 32'd0);
                if (prev_we) chk("wr_back_to_back", 32'd1, 32'd0);
                if (wr_exp.size() == 0) begin
                    chk("wr_unexpected", 32'(sp_if.sp_data_in), 32'hFFFF_FFFF);
                end else begin
                    e = wr_exp.pop_front();
                    chk("wr_data", 32'(sp_if.sp_data_in), 32'(e.dat));
                    chk("wr_ack", 32'({sp_if.ack1, sp_if.ack0}), e.who ? 32'd2 : 32'd1);
                    rd_exp.push_back(e.dat);
                end
            end else if (sp_if.ack0 || sp_if.ack1) begin
                chk("ack_without_write", 32'({sp_if.ack1, sp_if.ack0}), 32'd0);
            end
            prev_we = sp_if.sp_w_e;
            if (sp_if.sp_r_e) re_cnt++;
            if (sp_if.out_valid && sp_if.out_ready) begin
                if (rd_exp.size() == 0) chk("rd_unexpected", 32'(sp_if.out_data), 32'hFFFF_FFFF);
                else                    chk("rd_data", 32'(sp_if.out_data), 32'(rd_exp.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic who, input logic [7:0] dat);
        wexp_t e;
        e.dat = dat;
        e.who = who;
        if (who) q1.push_back(dat);
        else     q0.push_back(dat);
        wr_exp.push_back(e);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        ff_force = 1'b0;
        pl_vld   = 1'b0;
        prev_we  = 1'b0;
        q0.delete();
        q1.delete();
        wr_exp.delete();
        rd_exp.delete();
        #1;
        chk("reset_outputs", 32'({sp_if.ack0, sp_if.ack1, sp_if.sp_w_e, sp_if.sp_data_in,
                                  sp_if.sp_r_e, sp_if.out_valid, sp_if.out_data}), 32'd0);
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((wr_exp.size() != 0 || rd_exp.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({tag, "_drain"}, 32'(wr_exp.size() + rd_exp.size()), 32'd0);
    endtask

    initial begin
        int base;
        n_vec = 0; n_err = 0; wr_cnt = 0; re_cnt = 0;
        pl_dat = 8'h00;
        sp_if.out_ready = 1'b1;
        apply_reset();

        // single requester, write visible after the first sampling edge
        push_wr(1'b0, 8'h68);
        cyc(1);
        chk("t1_sp_w_e", 32'(sp_if.sp_w_e), 32'd1);
        chk("t1_data_in", 32'(sp_if.sp_data_in), 32'h68);
        chk("t1_ack0", 32'(sp_if.ack0), 32'd1);
        drain("t1", 60);

        // both requesters held
        apply_reset();
`ifdef SP_ARB_BURST_EN
        q0.push_back(8'hA0); q0.push_back(8'hA0);
        q1.push_back(8'hB1); q1.push_back(8'hB1);
        wr_exp.push_back('{8'hA0, 1'b0}); wr_exp.push_back('{8'hA0, 1'b0});
        wr_exp.push_back('{8'hB1, 1'b1}); wr_exp.push_back('{8'hB1, 1'b1});
`else
        for (int i = 0; i < 2; i++) begin
            push_wr(1'b0, 8'hA0);
            push_wr(1'b1, 8'hB1);
        end
`endif
        base = wr_cnt;
        cyc(8);
        chk("t2_writes_in_8", 32'(wr_cnt - base), 32'd4);
        drain("t2", 80);

        // full flag blocks writes until released
        ff_force = 1'b1;
        q0.push_back(8'h3C);
        base = wr_cnt;
        cyc(6);
        chk("t3_no_write_full", 32'(wr_cnt - base), 32'd0);
        chk("t3_req_held", 32'(sp_if.req0), 32'd1);
        wr_exp.push_back('{8'h3C, 1'b0});
        ff_force = 1'b0;
        cyc(1);
        chk("t3_write_after", 32'({sp_if.sp_w_e, sp_if.sp_data_in}), 32'h13C);
        drain("t3", 60);

        // drained byte held while consumer stalls
        sp_if.out_ready = 1'b0;
        base   = re_cnt;
        pl_vld = 1'b1;
        pl_dat = 8'h65; rd_exp.push_back(8'h65);
        cyc(1);
        pl_dat = 8'h6C; rd_exp.push_back(8'h6C);
        cyc(1);
        pl_vld = 1'b0;
        cyc(10);
        chk("t4_one_re_pulse", 32'(re_cnt - base), 32'd1);
        chk("t4_out_valid", 32'(sp_if.out_valid), 32'd1);
        chk("t4_out_data_held", 32'(sp_if.out_data), 32'h65);
        sp_if.out_ready = 1'b1;
        drain("t4", 60);
        cyc(5);
        chk("t4_total_re", 32'(re_cnt - base), 32'd2);
        chk("t4_empty_no_re", 32'({sp_if.sp_e_f, sp_if.sp_r_e}), 32'd2);

        // reset while a write and a fetch are both in flight
        pl_vld = 1'b1;
        pl_dat = 8'h77;
        cyc(1);
        pl_vld = 1'b0;
        q0.push_back(8'h22);
        cyc(1);
        chk("t5_inflight", 32'({sp_if.sp_w_e, sp_if.sp_r_e}), 32'd3);
        apply_reset();
        push_wr(1'b0, 8'h5A);
        push_wr(1'b1, 8'h5B);
        cyc(1);
        chk("t5_req0_first", 32'({sp_if.ack1, sp_if.ack0, sp_if.sp_data_in}), 32'h15A);
        drain("t5", 80);

`ifdef SP_ARB_BURST_EN
        // four-write burst for requester 0, then requester 1
        apply_reset();
        for (int i = 0; i < 5; i++) q0.push_back(8'hC0 + 8'(i));
        q1.push_back(8'hD0); q1.push_back(8'hD1);
        for (int i = 0; i < 4; i++) wr_exp.push_back('{8'hC0 + 8'(i), 1'b0});
        wr_exp.push_back('{8'hD0, 1'b1});
        wr_exp.push_back('{8'hD1, 1'b1});
        wr_exp.push_back('{8'hC4, 1'b0});
        drain("t6", 300);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
